// File: rtl/dcache_miss_queue.sv
// Purpose: miss-status queue between the dcache and the memory arbiter; merges duplicate block misses and returns fills in allocation order.
// Latency: allocation to mem_req_valid is 1 cycle; a matching data return reaches fill_valid 1 cycle later when the entry is head.
// Backpressure: miss_ready drops only for a non-merging miss while full; a request is held until the arbiter accepts it with a nonzero tag.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-low reset
//   miss_valid/miss_addr/miss_ready   miss handshake from the dcache (ready is combinational)
//   mem_req_valid/mem_req_addr        oldest unissued request toward the arbiter
//   mem_req_accepted/current_req_tag  arbiter accept and the tag assigned to it (tag 0 = refusal)
//   mem_data/mem_data_tag             returned block and its tag (tag 0 = no return)
//   fill_valid/fill_addr/fill_data    in-order fill to the dcache (always accepted)
//   count                             occupied entries, 0..DEPTH
module dcache_miss_queue #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 13,
    parameter int TAG_BITS  = 4,
    parameter int DATA_BITS = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   miss_valid,
    input  logic [ADDR_BITS-1:0]   miss_addr,
    output logic                   miss_ready,
    output logic                   mem_req_valid,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_accepted,
    input  logic [TAG_BITS-1:0]    current_req_tag,
    input  logic [DATA_BITS-1:0]   mem_data,
    input  logic [TAG_BITS-1:0]    mem_data_tag,
    output logic                   fill_valid,
    output logic [ADDR_BITS-1:0]   fill_addr,
    output logic [DATA_BITS-1:0]   fill_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        WAIT_ISSUE = 2'd1,
        WAIT_DATA  = 2'd2,
        DONE       = 2'd3
    } entry_state_t;

    entry_state_t         state [DEPTH];
    logic [ADDR_BITS-1:0] addr  [DEPTH];
    logic [TAG_BITS-1:0]  tag   [DEPTH];
    logic [DATA_BITS-1:0] data  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] issue;
    logic [PW-1:0] tail;

    logic merge_hit;
    logic alloc;
    logic issue_fire;
    logic retire;

    // A hit on any live entry merges, including one that retires this cycle:
    // the dcache is about to receive that very block.
    always_comb begin
        merge_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state[i] != EMPTY && addr[i] == miss_addr) begin
                merge_hit = 1'b1;
            end
        end
        merge_hit = merge_hit & miss_valid;
    end

    // Fullness uses the registered count only, so a same-cycle retire never
    // frees a slot for a new allocation.
    assign miss_ready    = reset & miss_valid & (merge_hit | (count < CW'(DEPTH)));
    assign alloc         = miss_valid & ~merge_hit & (count < CW'(DEPTH));

    assign mem_req_valid = (state[issue] == WAIT_ISSUE);
    assign mem_req_addr  = addr[issue];
    assign issue_fire    = mem_req_valid & mem_req_accepted & (current_req_tag != '0);

    assign fill_valid    = (state[head] == DONE);
    assign fill_addr     = addr[head];
    assign fill_data     = data[head];
    assign retire        = fill_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= EMPTY;
                addr[i]  <= '0;
                tag[i]   <= '0;
                data[i]  <= '0;
            end
            head  <= '0;
            issue <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // The four per-entry events always target distinct entries (each
            // needs a different current state), so one priority chain is safe.
            // The return compare sees registered state, so an entry accepted on
            // this edge is still WAIT_ISSUE here and cannot complete yet.
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && tail == PW'(i)) begin
                    state[i] <= WAIT_ISSUE;
                    addr[i]  <= miss_addr;
                    tag[i]   <= '0;
                end else if (issue_fire && issue == PW'(i)) begin
                    state[i] <= WAIT_DATA;
                    tag[i]   <= current_req_tag;
                end else if (state[i] == WAIT_DATA && mem_data_tag != '0 &&
                             tag[i] == mem_data_tag) begin
                    state[i] <= DONE;
                    data[i]  <= mem_data;
                end else if (retire && head == PW'(i)) begin
                    state[i] <= EMPTY;
                end
            end
            if (alloc)      tail  <= tail + 1'b1;
            if (issue_fire) issue <= issue + 1'b1;
            if (retire)     head  <= head + 1'b1;
            count <= count + CW'(alloc) - CW'(retire);
        end
    end

endmodule

// File: tb/tb_dcache_miss_queue.sv
module tb_dcache_miss_queue;

    logic        clock;
    logic        reset;
    logic        miss_valid;
    logic [12:0] miss_addr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [12:0] mem_req_addr;
    logic        mem_req_accepted;
    logic [3:0]  current_req_tag;
    logic [63:0] mem_data;
    logic [3:0]  mem_data_tag;
    logic        fill_valid;
    logic [12:0] fill_addr;
    logic [63:0] fill_data;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    dcache_miss_queue #(
        .DEPTH(4), .ADDR_BITS(13), .TAG_BITS(4), .DATA_BITS(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .miss_valid(miss_valid),
        .miss_addr(miss_addr),
        .miss_ready(miss_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr),
        .mem_req_accepted(mem_req_accepted),
        .current_req_tag(current_req_tag),
        .mem_data(mem_data),
        .mem_data_tag(mem_data_tag),
        .fill_valid(fill_valid),
        .fill_addr(fill_addr),
        .fill_data(fill_data),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", t, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic miss(input logic [12:0] a, input logic exp_rdy, input string t);
        miss_valid = 1'b1;
        miss_addr  = a;
        #1;
        chk(t, {63'd0, miss_ready}, {63'd0, exp_rdy});
        cyc();
        miss_valid = 1'b0;
        miss_addr  = '0;
    endtask

    task automatic accept(input logic [3:0] tg);
        mem_req_accepted = 1'b1;
        current_req_tag  = tg;
        cyc();
        mem_req_accepted = 1'b0;
        current_req_tag  = '0;
    endtask

    task automatic ret(input logic [3:0] tg, input logic [63:0] d);
        mem_data_tag = tg;
        mem_data     = d;
        cyc();
        mem_data_tag = '0;
        mem_data     = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        reset            = 1'b0;
        miss_valid       = 1'b0;
        miss_addr        = '0;
        mem_req_accepted = 1'b0;
        current_req_tag  = '0;
        mem_data         = '0;
        mem_data_tag     = '0;

        // ---- reset, then idle ----
        cyc();
        miss_valid = 1'b1;
        miss_addr  = 13'h0A0;
        #1;
        chk("rst_miss_ready_held", {63'd0, miss_ready}, 64'd0);
        miss_valid = 1'b0;
        miss_addr  = '0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("idle_miss_ready", {63'd0, miss_ready}, 64'd0);
        chk("idle_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("idle_fill_valid", {63'd0, fill_valid}, 64'd0);
        chk("idle_count", {61'd0, count}, 64'd0);

        // ---- single miss ----
        miss(13'h0A0, 1'b1, "single_ready");
        chk("single_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("single_req_addr", {51'd0, mem_req_addr}, 64'h0A0);
        chk("single_count1", {61'd0, count}, 64'd1);
        accept(4'd3);
        chk("single_req_dropped", {63'd0, mem_req_valid}, 64'd0);
        chk("single_no_fill_yet", {63'd0, fill_valid}, 64'd0);
        ret(4'd3, 64'hDEAD_BEEF_0000_0001);
        chk("single_fill_valid", {63'd0, fill_valid}, 64'd1);
        chk("single_fill_addr", {51'd0, fill_addr}, 64'h0A0);
        chk("single_fill_data", fill_data, 64'hDEAD_BEEF_0000_0001);
        cyc();
        chk("single_fill_gone", {63'd0, fill_valid}, 64'd0);
        chk("single_count0", {61'd0, count}, 64'd0);

        // ---- merge ----
        miss(13'h010, 1'b1, "merge_first_ready");
        accept(4'd5);
        miss(13'h010, 1'b1, "merge_dup_ready");
        chk("merge_count", {61'd0, count}, 64'd1);
        chk("merge_no_second_req", {63'd0, mem_req_valid}, 64'd0);
        ret(4'd5, 64'h0000_0000_0000_0010);
        chk("merge_fill_addr", {51'd0, fill_addr}, 64'h010);
        chk("merge_fill_valid", {63'd0, fill_valid}, 64'd1);
        cyc();
        chk("merge_single_fill", {63'd0, fill_valid}, 64'd0);
        chk("merge_count0", {61'd0, count}, 64'd0);

        // ---- full and wrap (fresh pointers) ----
        pulse_reset();
        for (int k = 1; k <= 4; k++) miss(13'(k), 1'b1, "full_alloc_ready");
        chk("full_count4", {61'd0, count}, 64'd4);
        miss(13'h005, 1'b0, "full_reject");
        miss(13'h003, 1'b1, "full_merge");
        chk("full_count_still4", {61'd0, count}, 64'd4);
        chk("full_issue_addr1", {51'd0, mem_req_addr}, 64'h001);
        accept(4'd1);
        ret(4'd1, 64'h1111);
        chk("full_fill1_valid", {63'd0, fill_valid}, 64'd1);
        chk("full_fill1_addr", {51'd0, fill_addr}, 64'h001);
        // head retires on this edge but the queue is still full beforehand
        miss(13'h005, 1'b0, "full_reject_during_retire");
        chk("full_drop_to3", {61'd0, count}, 64'd3);
        miss(13'h005, 1'b1, "wrap_alloc_ready");
        chk("wrap_count4", {61'd0, count}, 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_issue_order", {51'd0, mem_req_addr}, (k == 3) ? 64'h005 : 64'(k + 2));
            accept(4'(k + 2));
        end
        chk("wrap_all_issued", {63'd0, mem_req_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            ret(4'(k + 2), 64'(k) + 64'hA000);
            chk("wrap_fill_valid", {63'd0, fill_valid}, 64'd1);
            chk("wrap_fill_addr", {51'd0, fill_addr}, (k == 3) ? 64'h005 : 64'(k + 2));
            chk("wrap_fill_data", fill_data, 64'(k) + 64'hA000);
        end
        cyc();
        chk("wrap_drained", {61'd0, count}, 64'd0);

        // ---- out-of-order returns ----
        miss(13'h020, 1'b1, "ooo_ready_a");
        miss(13'h021, 1'b1, "ooo_ready_b");
        chk("ooo_req_a", {51'd0, mem_req_addr}, 64'h020);
        accept(4'd1);
        chk("ooo_req_b", {51'd0, mem_req_addr}, 64'h021);
        accept(4'd2);
        ret(4'd2, 64'hBBBB);
        chk("ooo_young_waits", {63'd0, fill_valid}, 64'd0);
        ret(4'd1, 64'hAAAA);
        chk("ooo_fill_a_valid", {63'd0, fill_valid}, 64'd1);
        chk("ooo_fill_a_addr", {51'd0, fill_addr}, 64'h020);
        chk("ooo_fill_a_data", fill_data, 64'hAAAA);
        cyc();
        chk("ooo_fill_b_valid", {63'd0, fill_valid}, 64'd1);
        chk("ooo_fill_b_addr", {51'd0, fill_addr}, 64'h021);
        chk("ooo_fill_b_data", fill_data, 64'hBBBB);
        cyc();
        chk("ooo_count0", {61'd0, count}, 64'd0);

        // ---- accept and return with the same tag on one edge ----
        miss(13'h040, 1'b1, "same_edge_ready");
        mem_req_accepted = 1'b1;
        current_req_tag  = 4'd9;
        mem_data_tag     = 4'd9;
        mem_data         = 64'h9999;
        cyc();
        mem_req_accepted = 1'b0;
        current_req_tag  = '0;
        mem_data_tag     = '0;
        mem_data         = '0;
        chk("same_edge_no_fill", {63'd0, fill_valid}, 64'd0);
        ret(4'd9, 64'h9090);
        chk("same_edge_later_fill", {63'd0, fill_valid}, 64'd1);
        chk("same_edge_later_data", fill_data, 64'h9090);
        cyc();

        // ---- refusal, stray tag, async reset ----
        miss(13'h030, 1'b1, "refuse_ready");
        accept(4'd0);
        chk("refuse_req_held", {63'd0, mem_req_valid}, 64'd1);
        chk("refuse_req_addr", {51'd0, mem_req_addr}, 64'h030);
        accept(4'd6);
        chk("refuse_then_taken", {63'd0, mem_req_valid}, 64'd0);
        ret(4'd7, 64'h7777);
        chk("stray_no_fill", {63'd0, fill_valid}, 64'd0);
        chk("stray_count", {61'd0, count}, 64'd1);
        miss(13'h031, 1'b1, "pending_ready");
        chk("pending_count2", {61'd0, count}, 64'd2);
        chk("pending_req_addr", {51'd0, mem_req_addr}, 64'h031);
        reset = 1'b0;
        #1;
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("arst_req_addr", {51'd0, mem_req_addr}, 64'd0);
        chk("arst_fill_valid", {63'd0, fill_valid}, 64'd0);
        chk("arst_fill_addr", {51'd0, fill_addr}, 64'd0);
        chk("arst_fill_data", fill_data, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        ret(4'd6, 64'h6666);
        chk("old_tag_no_fill", {63'd0, fill_valid}, 64'd0);
        chk("old_tag_count", {61'd0, count}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_miss_queue.md
Name: dcache_miss_queue

Overview:
- Miss-status queue directly downstream of the data cache.
- Accepts block-address misses from the dcache and issues one memory request per distinct block to the memory arbiter.
- Tracks the memory tags it is handed, captures returned blocks, and delivers fills back to the dcache in allocation order.
- Duplicate misses to a block already in flight are merged, not re-requested.

Parameters:
- DEPTH, 4, number of miss entries (power of two, ≥2).
- ADDR_BITS, 13, block-address width (byte address without the 3-bit block offset).
- TAG_BITS, 4, memory transaction tag width; tag value 0 means "no tag".
- DATA_BITS, 64, memory block width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- miss_valid  in  1  dcache presents a miss this cycle.
- miss_addr  in  ADDR_BITS  block address of the miss.
- miss_ready  out  1  miss accepted this cycle (allocated or merged).
- mem_req_valid  out  1  request pending toward arbiter.
- mem_req_addr  out  ADDR_BITS  block address of pending request.
- mem_req_accepted  in  1  arbiter took the request this cycle.
- current_req_tag  in  TAG_BITS  tag memory assigned to the accepted request.
- mem_data  in  DATA_BITS  returned block.
- mem_data_tag  in  TAG_BITS  tag of returned block; 0 = no return.
- fill_valid  out  1  completed block delivered to dcache this cycle.
- fill_addr  out  ADDR_BITS  block address of fill.
- fill_data  out  DATA_BITS  block data of fill.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding state, addr, tag, data. Pointers head (oldest), issue (next to request), tail (next free); each wraps modulo DEPTH. count is a separate register, 0..DEPTH.
- Per-entry state machine:
  - EMPTY -> WAIT_ISSUE on allocation.
  - WAIT_ISSUE -> WAIT_DATA when mem_req_accepted=1 and current_req_tag≠0, at the issue entry.
  - WAIT_DATA -> DONE when mem_data_tag≠0 and equals the stored tag.
  - DONE -> EMPTY when the entry is head and fill fires.
- Reset (reset=0, asynchronous): all entries EMPTY, pointers and count 0. miss_ready, mem_req_valid, fill_valid read 0; addr, data and tag outputs read 0.
- Allocation/merge (combinational ready):
  - merge_hit = miss_valid and miss_addr equals addr of any non-EMPTY entry.
  - miss_ready = miss_valid and (merge_hit or count<DEPTH).
  - A merge allocates nothing.
  - Otherwise allocate at tail on the next edge and increment tail.
  - A hit on the entry retiring in the same cycle is still a merge.
- Full: with count==DEPTH, miss_ready=0 for non-merging misses, even if head retires that cycle.
- Issue:
  - mem_req_valid = entry[issue].state==WAIT_ISSUE; mem_req_addr = entry[issue].addr. Combinational, held stable until accepted.
  - Accept with tag 0 is a refusal: no state change, request stays asserted.
  - Requests issue strictly in allocation order; issue advances on a successful accept.
- Return:
  - Tag compare covers only WAIT_DATA entries registered before this edge, so an entry accepted this cycle cannot complete this cycle.
  - A return whose tag matches no WAIT_DATA entry is ignored.
  - At most one entry matches; tags are unique while outstanding.
- Fill:
  - fill_valid = entry[head].state==DONE; fill_addr and fill_data come from head. Combinational.
  - The dcache always accepts, so head retires on the same edge and head advances.
  - Fills are in allocation order; a younger DONE entry waits behind an older WAIT_DATA entry.
- Simultaneous events on one edge (allocate, issue accept, data return, head retire) all take effect together.
  - count_next = count + alloc − retire.
  - A full queue with retire and no alloc drops to DEPTH−1.
- Latency:
  - Allocation to earliest mem_req_valid: 1 cycle.
  - Matching return to fill_valid: 1 cycle, when the entry is head.
- Reset mid-operation: all in-flight state is discarded. Later returns carrying old tags match nothing and are ignored.

Test Plan:
- Reset then idle: after reset release, miss_ready=0, mem_req_valid=0, fill_valid=0, count=0.
- Single miss: miss_addr=0x0A0 -> next cycle mem_req_valid=1, addr 0x0A0. Accept with tag 3. Return tag 3, data 0xDEAD_BEEF_0000_0001 -> next cycle fill_valid=1 with that addr and data; count 1→0.
- Merge: miss 0x010, then a second miss 0x010 while in WAIT_DATA -> miss_ready=1, count stays 1, exactly one memory request, one fill.
- Full and wrap: allocate 0x1,0x2,0x3,0x4 (count=4) -> miss 0x5 gets miss_ready=0, miss 0x3 gets miss_ready=1 (merge). Retire 0x1, then 0x5 allocates into slot 0 (wrap).
- Out-of-order returns: 0x20 (tag 1) and 0x21 (tag 2) outstanding; tag 2 returns first -> no fill. Tag 1 returns -> fill 0x20, then fill 0x21 on the next cycle.
- Refusal and stray tags: accept with current_req_tag=0 -> request stays asserted, same addr. Return with unmatched tag 7 -> no state change. Async reset asserted while entries pending -> all outputs 0 immediately; a later return of the old tag produces no fill.
